// File: rtl/fetch_cycle_if.sv
// rtl/fetch_cycle_if.sv - instruction memory request/response channel
`timescale 1ns/1ps
interface fetch_cycle_if #(
    parameter int XLEN               = 64,
    parameter int INSTRUCTION_LENGTH = 32
);
    logic                          imem_req_valid;
    logic                          imem_req_ready;
    logic [XLEN-1:0]               imem_req_addr;
    logic                          imem_resp_valid;
    logic [INSTRUCTION_LENGTH-1:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

// File: rtl/fetch_cycle.sv
// rtl/fetch_cycle.sv - fetch stage: PC, single-outstanding imem requests, instruction buffer
`timescale 1ns/1ps
module fetch_cycle #(
    parameter int            XLEN               = 64,
    parameter int            INSTRUCTION_LENGTH = 32,
    parameter bit [XLEN-1:0] RESET_PC           = '0,
    parameter int            FIFO_DEPTH         = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    fetch_cycle_if.master                 imem,
    input  logic                          redirect_valid,
    input  logic [XLEN-1:0]               redirect_pc,
    input  logic                          f_to_d_enable_ff,
    output logic                          fetch_valid,
    output logic [INSTRUCTION_LENGTH-1:0] instruction,
    output logic [XLEN-1:0]               PC_out
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [INSTRUCTION_LENGTH-1:0] NOP = INSTRUCTION_LENGTH'(32'h0000_0013);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t                        state, state_next;
    logic [XLEN-1:0]               fetch_pc;
    logic [XLEN-1:0]               req_pc;
    logic [CNT_W-1:0]              count;
    logic [PTR_W-1:0]              rd_ptr;
    logic [PTR_W-1:0]              wr_ptr;
    logic [XLEN-1:0]               pc_mem    [FIFO_DEPTH];
    logic [INSTRUCTION_LENGTH-1:0] instr_mem [FIFO_DEPTH];

    logic req_valid;
    logic req_fire;
    logic resp_owed;
    logic push;
    logic pop;

    // With only one request in flight, a free slot now is a slot for its response.
    assign req_valid = (state == REQ) && (count < CNT_W'(FIFO_DEPTH));
    assign req_fire  = req_valid && imem.imem_req_ready;
    assign push      = (state == WAIT) && imem.imem_resp_valid && !redirect_valid;
    assign pop       = fetch_valid && f_to_d_enable_ff && !redirect_valid;
    assign resp_owed = ((state == WAIT || state == DROP) && !imem.imem_resp_valid) || req_fire;

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_req_addr  = fetch_pc;

    assign fetch_valid = (count != '0);
    assign instruction = fetch_valid ? instr_mem[rd_ptr] : NOP;
    assign PC_out      = fetch_valid ? pc_mem[rd_ptr] : '0;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: state_next = REQ;
            REQ:  if (req_fire) state_next = WAIT;
            WAIT: if (imem.imem_resp_valid) state_next = REQ;
            DROP: if (imem.imem_resp_valid) state_next = REQ;
            default: state_next = IDLE;
        endcase
        if (redirect_valid) begin
            state_next = resp_owed ? DROP : REQ;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            state <= state_next;
            if (req_fire) begin
                req_pc <= fetch_pc;
            end
            if (redirect_valid) begin
                fetch_pc <= redirect_pc & ~XLEN'(3);
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Buffer storage needs no reset: entries are only visible while count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= req_pc;
            instr_mem[wr_ptr] <= imem.imem_resp_data;
        end
    end
endmodule

// File: tb/tb_fetch_cycle.sv
// tb/tb_fetch_cycle.sv - self-checking bench for fetch_cycle
`timescale 1ns/1ps
module tb_fetch_cycle;
    localparam int          XLEN  = 64;
    localparam int          IL    = 32;
    localparam int          DEPTH = 2;
    localparam logic [63:0] RPC   = 64'h0;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] ins;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        en = 1'b1;
    logic        fetch_valid;
    logic [31:0] instruction;
    logic [63:0] PC_out;

    fetch_cycle_if #(.XLEN(XLEN), .INSTRUCTION_LENGTH(IL)) m ();

    fetch_cycle #(
        .XLEN(XLEN), .INSTRUCTION_LENGTH(IL), .RESET_PC(RPC), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem(m),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .f_to_d_enable_ff(en),
        .fetch_valid(fetch_valid),
        .instruction(instruction),
        .PC_out(PC_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Memory: one pending request, answered after a random latency.
    bit          pend_valid = 0;
    bit          pend_drop  = 0;
    logic [63:0] pend_addr  = '0;
    int          pend_lat   = 0;
    int          lat_min    = 1;
    int          lat_max    = 1;

    // Reference: instructions decode should see, in order, and the next fetch address.
    ent_t        mq[$];
    logic [63:0] exp_addr = RPC;

    bit          hs_seen, pop_seen;
    logic [63:0] hs_addr, pop_pc;
    logic [31:0] pop_ins;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_0000;
    endfunction

    task automatic tick();
        bit hs, rs, rd, mpop;
        hs = m.imem_req_valid && m.imem_req_ready;
        rs = m.imem_resp_valid;
        rd = redirect_valid;
        hs_seen  = hs;
        hs_addr  = m.imem_req_addr;
        pop_seen = fetch_valid && en;
        pop_pc   = PC_out;
        pop_ins  = instruction;
        if (rst) begin
            mq.delete();
            pend_valid = 0;
            exp_addr   = RPC;
        end else begin
            mpop = en && (mq.size() > 0);
            if (rd) begin
                mq.delete();
                exp_addr = redirect_pc & ~64'h3;
            end else begin
                if (mpop) void'(mq.pop_front());
                if (rs && pend_valid && !pend_drop) mq.push_back('{pend_addr, m.imem_resp_data});
            end
            if (rs) pend_valid = 0;
            else if (rd && pend_valid) pend_drop = 1;
            if (hs) begin
                pend_valid = 1;
                pend_addr  = m.imem_req_addr;
                pend_drop  = rd;
                pend_lat   = $urandom_range(lat_max, lat_min);
                if (!rd) exp_addr = exp_addr + 64'd4;
            end
        end
        @(posedge clk);
        #1;
        m.imem_resp_valid = 1'b0;
        if (pend_valid && !rst) begin
            pend_lat--;
            if (pend_lat == 0) begin
                m.imem_resp_valid = 1'b1;
                m.imem_resp_data  = mem_word(pend_addr);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        m.imem_resp_valid = 1'b0;
        m.imem_resp_data = '0;
        m.imem_req_ready = 1'b1;
        en = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        m.imem_req_ready = 1'b1;
        m.imem_resp_valid = 1'b0;
        m.imem_resp_data = '0;
        #1 rst = 1'b1;
        #1;
        checks++; if (m.imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got=%0b exp=0", m.imem_req_valid); end
        checks++; if (m.imem_req_addr !== RPC) begin errors++; $display("FAIL reset_req_addr got=%h exp=%h", m.imem_req_addr, RPC); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fetch_valid got=%0b exp=0", fetch_valid); end
        checks++; if (instruction !== NOP) begin errors++; $display("FAIL reset_instruction got=%h exp=%h", instruction, NOP); end
        checks++; if (PC_out !== 64'h0) begin errors++; $display("FAIL reset_pc_out got=%h exp=0", PC_out); end
        tick();
        rst = 1'b0;
        checks++; if (m.imem_req_valid !== 1'b0) begin errors++; $display("FAIL idle_req_valid got=%0b exp=0", m.imem_req_valid); end
        tick();
        checks++; if (m.imem_req_valid !== 1'b1 || m.imem_req_addr !== RPC) begin
            errors++; $display("FAIL first_req got_valid=%0b got_addr=%h exp_valid=1 exp_addr=%h", m.imem_req_valid, m.imem_req_addr, RPC);
        end
    endtask

    task automatic test_sequential();
        logic [63:0] reqs[$];
        ent_t        pops[$];
        int          first_fv;
        lat_min = 1; lat_max = 1;
        do_reset();
        first_fv = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (hs_seen) reqs.push_back(hs_addr);
            if (pop_seen) pops.push_back('{pop_pc, pop_ins});
            if (fetch_valid && first_fv < 0) first_fv = i;
        end
        checks++; if (first_fv != 3) begin errors++; $display("FAIL seq_first_valid got=%0d exp=3", first_fv); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (reqs.size() <= k || reqs[k] !== 64'(4 * k)) begin
                errors++; $display("FAIL seq_req_addr idx=%0d got=%h exp=%h", k, (reqs.size() > k) ? reqs[k] : 64'hX, 64'(4 * k));
            end
            checks++;
            if (pops.size() <= k || pops[k].pc !== 64'(4 * k) || pops[k].ins !== mem_word(64'(4 * k))) begin
                errors++; $display("FAIL seq_decode idx=%0d got_pc=%h got_ins=%h exp_pc=%h",
                                   k, (pops.size() > k) ? pops[k].pc : 64'hX, (pops.size() > k) ? pops[k].ins : 32'hX, 64'(4 * k));
            end
        end
    endtask

    task automatic test_stall();
        int          nreq, frozen_bad, npop, first_pop_tick;
        logic [63:0] pcs[$];
        logic [63:0] next_req;
        bit          got_req;
        lat_min = 1; lat_max = 1;
        do_reset();
        en = 1'b0;
        nreq = 0; frozen_bad = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (hs_seen) nreq++;
            if (i >= 3 && (fetch_valid !== 1'b1 || PC_out !== 64'h0 || instruction !== mem_word(64'h0))) frozen_bad++;
        end
        checks++; if (nreq != 2) begin errors++; $display("FAIL stall_req_count got=%0d exp=2", nreq); end
        checks++; if (frozen_bad != 0) begin errors++; $display("FAIL stall_frozen bad_cycles=%0d exp=0", frozen_bad); end
        en = 1'b1;
        npop = 0; first_pop_tick = -1; got_req = 0; next_req = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (pop_seen) begin
                pcs.push_back(pop_pc);
                if (first_pop_tick < 0) first_pop_tick = i;
                if (pcs.size() == 2 && first_pop_tick != i - 1) npop = -1;
            end
            if (hs_seen && !got_req) begin got_req = 1; next_req = hs_addr; end
        end
        checks++; if (pcs.size() < 2 || pcs[0] !== 64'h0 || pcs[1] !== 64'h4 || npop != 0 || first_pop_tick != 0) begin
            errors++; $display("FAIL stall_release_pops n=%0d first=%h second=%h exp=0,4 consecutive",
                               pcs.size(), (pcs.size() > 0) ? pcs[0] : 64'hX, (pcs.size() > 1) ? pcs[1] : 64'hX);
        end
        checks++; if (!got_req || next_req !== 64'h8) begin errors++; $display("FAIL stall_resume_addr got=%h exp=8", next_req); end
    endtask

    task automatic test_redirect_wait();
        int          n;
        bit          saw8, early_fv, got_req, got_fv;
        logic [63:0] first_req, first_pc;
        lat_min = 3; lat_max = 3;
        do_reset();
        n = 0;
        do begin tick(); n++; end while (!(hs_seen && hs_addr == 64'h8) && n < 60);
        checks++; if (n >= 60) begin errors++; $display("FAIL redir_wait_timeout got=no_req_8 exp=req_8"); end
        redirect_valid = 1'b1; redirect_pc = 64'h100;
        tick();
        redirect_valid = 1'b0;
        checks++; if (fetch_valid !== 1'b0 || instruction !== NOP || PC_out !== 64'h0) begin
            errors++; $display("FAIL redir_wait_flush got_fv=%0b got_ins=%h got_pc=%h exp=0/%h/0", fetch_valid, instruction, PC_out, NOP);
        end
        saw8 = 0; early_fv = 0; got_req = 0; got_fv = 0; first_req = '0; first_pc = '0;
        for (int i = 0; i < 30; i++) begin
            if (fetch_valid && PC_out == 64'h8) saw8 = 1;
            if (fetch_valid && !got_fv) begin got_fv = 1; first_pc = PC_out; if (!got_req) early_fv = 1; end
            tick();
            if (hs_seen && !got_req) begin got_req = 1; first_req = hs_addr; end
        end
        checks++; if (first_req !== 64'h100) begin errors++; $display("FAIL redir_wait_next_addr got=%h exp=100", first_req); end
        checks++; if (saw8 || early_fv || !got_fv || first_pc !== 64'h100) begin
            errors++; $display("FAIL redir_wait_decode saw8=%0b early=%0b got_pc=%h exp_pc=100", saw8, early_fv, first_pc);
        end
    endtask

    task automatic test_redirect_handshake();
        int          n, req_while_owed;
        bit          got_req, got_fv;
        logic [63:0] first_req, first_pc;
        lat_min = 2; lat_max = 2;
        do_reset();
        n = 0;
        while (!(m.imem_req_valid && m.imem_req_addr == 64'h8) && n < 60) begin tick(); n++; end
        checks++; if (n >= 60) begin errors++; $display("FAIL redir_hs_timeout got=no_valid exp=valid_at_8"); end
        redirect_valid = 1'b1; redirect_pc = 64'h203;
        tick();
        redirect_valid = 1'b0;
        got_req = 0; got_fv = 0; first_req = '0; first_pc = '0; req_while_owed = 0;
        for (int i = 0; i < 20; i++) begin
            if (m.imem_req_valid && pend_valid) req_while_owed++;
            if (fetch_valid && !got_fv) begin got_fv = 1; first_pc = PC_out; end
            tick();
            if (hs_seen && !got_req) begin got_req = 1; first_req = hs_addr; end
        end
        checks++; if (req_while_owed != 0) begin errors++; $display("FAIL redir_hs_drop req_while_owed=%0d exp=0", req_while_owed); end
        checks++; if (first_req !== 64'h200) begin errors++; $display("FAIL redir_hs_next_addr got=%h exp=200", first_req); end
        checks++; if (!got_fv || first_pc !== 64'h200) begin errors++; $display("FAIL redir_hs_decode got_pc=%h exp=200", first_pc); end
    endtask

    task automatic test_ready_low();
        int          n;
        logic [63:0] addr0, nxt;
        bit          got;
        lat_min = 1; lat_max = 1;
        do_reset();
        m.imem_req_ready = 1'b0;
        n = 0;
        while (!m.imem_req_valid && n < 10) begin tick(); n++; end
        addr0 = m.imem_req_addr;
        for (int i = 0; i < 5; i++) begin
            checks++; if (m.imem_req_valid !== 1'b1 || m.imem_req_addr !== RPC) begin
                errors++; $display("FAIL ready_low_hold cyc=%0d got_valid=%0b got_addr=%h exp=1/%h", i, m.imem_req_valid, m.imem_req_addr, RPC);
            end
            tick();
        end
        m.imem_req_ready = 1'b1;
        tick();
        checks++; if (!hs_seen || hs_addr !== RPC) begin errors++; $display("FAIL ready_low_accept got_hs=%0b got_addr=%h exp=1/%h", hs_seen, hs_addr, RPC); end
        got = 0; nxt = '0;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            if (hs_seen) begin got = 1; nxt = hs_addr; end
        end
        checks++; if (!got || nxt !== addr0 + 64'd4) begin errors++; $display("FAIL ready_low_next_addr got=%h exp=%h", nxt, addr0 + 64'd4); end
    endtask

    task automatic test_reset_mid();
        int          n;
        bit          got;
        logic [63:0] a;
        lat_min = 3; lat_max = 3;
        do_reset();
        en = 1'b0;
        n = 0;
        while (!(fetch_valid && pend_valid && !m.imem_resp_valid) && n < 40) begin tick(); n++; end
        checks++; if (n >= 40) begin errors++; $display("FAIL rst_mid_setup got=no_wait_state exp=wait_with_entry"); end
        #2;
        rst = 1'b1;
        m.imem_resp_valid = 1'b0;
        #1;
        checks++; if (fetch_valid !== 1'b0 || instruction !== NOP || PC_out !== 64'h0) begin
            errors++; $display("FAIL rst_mid_outputs got_fv=%0b got_ins=%h got_pc=%h exp=0/%h/0", fetch_valid, instruction, PC_out, NOP);
        end
        checks++; if (m.imem_req_valid !== 1'b0 || m.imem_req_addr !== RPC) begin
            errors++; $display("FAIL rst_mid_req got_valid=%0b got_addr=%h exp=0/%h", m.imem_req_valid, m.imem_req_addr, RPC);
        end
        tick();
        rst = 1'b0;
        en = 1'b1;
        got = 0; a = '1;
        for (int i = 0; i < 6 && !got; i++) begin
            tick();
            if (hs_seen) begin got = 1; a = hs_addr; end
        end
        checks++; if (!got || a !== RPC) begin errors++; $display("FAIL rst_mid_restart got=%h exp=%h", a, RPC); end
    endtask

    task automatic test_random();
        bit          exp_fv, prev_valid, prev_ready, prev_redir;
        logic [31:0] exp_ins;
        logic [63:0] exp_pc, prev_addr;
        int          npop;
        lat_min = 1; lat_max = 4;
        do_reset();
        npop = 0; prev_valid = 0; prev_ready = 0; prev_redir = 0; prev_addr = '0;
        for (int i = 0; i < 3000; i++) begin
            m.imem_req_ready = ($urandom_range(3, 0) != 0);
            en = ($urandom_range(9, 0) < 7);
            redirect_valid = ($urandom_range(19, 0) == 0);
            case ($urandom_range(3, 0))
                0:       redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
                1:       redirect_pc = {$urandom(), $urandom()};
                default: redirect_pc = {32'h0, 32'($urandom_range(32'hFFFF, 0))};
            endcase
            exp_fv  = (mq.size() != 0);
            exp_ins = exp_fv ? mq[0].ins : NOP;
            exp_pc  = exp_fv ? mq[0].pc : 64'h0;
            checks++; if (fetch_valid !== exp_fv) begin errors++; $display("FAIL rnd_fetch_valid cyc=%0d got=%0b exp=%0b", i, fetch_valid, exp_fv); end
            checks++; if (instruction !== exp_ins) begin errors++; $display("FAIL rnd_instruction cyc=%0d got=%h exp=%h", i, instruction, exp_ins); end
            checks++; if (PC_out !== exp_pc) begin errors++; $display("FAIL rnd_pc_out cyc=%0d got=%h exp=%h", i, PC_out, exp_pc); end
            if (i > 0) begin
                checks++; if (m.imem_req_valid !== (!pend_valid && mq.size() < DEPTH)) begin
                    errors++; $display("FAIL rnd_req_valid cyc=%0d got=%0b exp=%0b", i, m.imem_req_valid, !pend_valid && mq.size() < DEPTH);
                end
            end
            if (prev_valid && !prev_ready && !prev_redir) begin
                checks++; if (m.imem_req_valid !== 1'b1 || m.imem_req_addr !== prev_addr) begin
                    errors++; $display("FAIL rnd_req_hold cyc=%0d got=%0b/%h exp=1/%h", i, m.imem_req_valid, m.imem_req_addr, prev_addr);
                end
            end
            if (m.imem_req_valid && m.imem_req_ready) begin
                checks++; if (m.imem_req_addr !== exp_addr) begin errors++; $display("FAIL rnd_req_addr cyc=%0d got=%h exp=%h", i, m.imem_req_addr, exp_addr); end
            end
            prev_valid = m.imem_req_valid; prev_ready = m.imem_req_ready;
            prev_redir = redirect_valid;   prev_addr  = m.imem_req_addr;
            tick();
            if (pop_seen) npop++;
        end
        redirect_valid = 1'b0;
        checks++; if (npop < 100) begin errors++; $display("FAIL rnd_progress got=%0d exp>=100", npop); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_handshake();
        test_ready_low();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
